// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: fetch FSM state
// encoding, default widths, the halt opcode and instruction field positions.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam int unsigned FETCH_ADDR_W = 6;
   localparam int unsigned FETCH_CODE_W = 23;
   localparam int unsigned FETCH_OP_W   = 3;
   localparam int unsigned FETCH_RD_W   = 4;
   localparam int unsigned FETCH_IMM_W  = 16;

   localparam logic [FETCH_OP_W-1:0] FETCH_HALT_OP = 3'b111;

   // code word layout {op, rd, imm}
   localparam int unsigned OP_MSB  = FETCH_CODE_W - 1;
   localparam int unsigned OP_LSB  = FETCH_CODE_W - FETCH_OP_W;
   localparam int unsigned RD_MSB  = OP_LSB - 1;
   localparam int unsigned RD_LSB  = FETCH_IMM_W;
   localparam int unsigned IMM_MSB = FETCH_IMM_W - 1;
   localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller.
// Holds the PC, addresses the combinational instruction memory and captures
// each code word into an instruction register handed to decode over a
// valid/ready handshake. Supports start, halt-on-opcode and redirect with flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    pulse: leave IDLE and fetch from current pc
//   imem_addr / imem_code    instruction memory address (== pc) / read data
//   ir_valid/ir_ready        handshake to decode
//   ir_code, ir_pc           captured word and the address it came from
//   redirect_valid/_addr     load pc and flush the instruction register
//   pc                       current fetch address
//   halted                   1 while in HALT
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned          ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned          CODE_W   = FETCH_CODE_W,
   parameter int unsigned          OP_W     = FETCH_OP_W,
   parameter logic [OP_W-1:0]      HALT_OP  = FETCH_HALT_OP,
   parameter int unsigned          RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [CODE_W-1:0] imem_code,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [CODE_W-1:0] ir_code,
   output logic [ADDR_W-1:0] ir_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_t state;
   logic         slot_free;
   logic         is_halt_op;

   assign imem_addr  = pc;
   assign slot_free  = !ir_valid || ir_ready;
   assign is_halt_op = (imem_code[CODE_W-1 -: OP_W] == HALT_OP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= ADDR_W'(RESET_PC);
         ir_valid <= 1'b0;
         ir_code  <= '0;
         ir_pc    <= '0;
         halted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // redirect may preload pc before start; ir stays empty here
               if (redirect_valid)
                  pc <= redirect_addr;
               if (start)
                  state <= FETCH;
            end

            FETCH, HALT: begin
               // redirect wins over capture, drain and halt detection
               if (redirect_valid) begin
                  pc       <= redirect_addr;
                  ir_valid <= 1'b0;
                  state    <= FETCH;
                  halted   <= 1'b0;
               end else if (state == FETCH && slot_free) begin
                  ir_code  <= imem_code;
                  ir_pc    <= pc;
                  ir_valid <= 1'b1;
                  pc       <= pc + ADDR_W'(1);
                  if (is_halt_op) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end else if (ir_valid && ir_ready) begin
                  ir_valid <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               ir_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

   localparam int unsigned AW = 6;
   localparam int unsigned CW = 23;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   // dut0: default RESET_PC, bench IM program
   logic          rst = 1'b1, start = 1'b0, ir_ready = 1'b1;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic [AW-1:0] imem_addr, ir_pc, pc;
   logic [CW-1:0] imem_code, ir_code;
   logic          ir_valid, halted;

   // dut1: RESET_PC=62, IM all zero
   logic          rst1 = 1'b1, start1 = 1'b0;
   logic [AW-1:0] imem_addr1, ir_pc1, pc1;
   logic [CW-1:0] ir_code1;
   logic          ir_valid1, halted1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [CW-1:0] c;
   } sb_item_t;
   sb_item_t sb[$];

   function automatic logic [CW-1:0] im_word(input logic [AW-1:0] a);
      if (a < 6'd5)      return {3'b000, a[3:0], 10'd0, a};
      else if (a == 6'd5) return {3'b111, 4'h0, 16'h0};
      else               return '0;
   endfunction

   assign imem_code = im_word(imem_addr);

   instr_fetch_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_code(imem_code),
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .ir_code(ir_code), .ir_pc(ir_pc),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .pc(pc), .halted(halted)
   );

   instr_fetch_ctrl #(.RESET_PC(62)) dut1 (
      .clk(clk), .rst(rst1), .start(start1),
      .imem_addr(imem_addr1), .imem_code('0),
      .ir_valid(ir_valid1), .ir_ready(1'b1),
      .ir_code(ir_code1), .ir_pc(ir_pc1),
      .redirect_valid(1'b0), .redirect_addr('0),
      .pc(pc1), .halted(halted1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int unsigned lo, input int unsigned hi);
      sb_item_t it;
      for (int unsigned k = lo; k <= hi; k++) begin
         it.a = AW'(k);
         it.c = im_word(AW'(k));
         sb.push_back(it);
      end
   endtask

   // accepted words are popped off the scoreboard; a redirect drops the held word
   always @(negedge clk) begin
      if (!rst && ir_valid && ir_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_word", 32'(sb.size()), 32'd1);
         end else begin
            sb_item_t e;
            e = sb.pop_front();
            check_eq("sb_ir_pc", 32'(ir_pc), 32'(e.a));
            check_eq("sb_ir_code", 32'(ir_code), 32'(e.c));
         end
      end
   end

   initial begin
      // ---- reset state
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_ir_valid", 32'(ir_valid), 0);
      check_eq("rst_pc", 32'(pc), 0);
      check_eq("rst_halted", 32'(halted), 0);
      check_eq("rst_ir_code", 32'(ir_code), 0);
      check_eq("rst_imem_addr", 32'(imem_addr), 0);
      tick();
      check_eq("idle_no_fetch", 32'(ir_valid), 0);

      // ---- 1: start, stream 0..5, halt
      push_range(0, 5);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("s1_lat_valid", 32'(ir_valid), 0);
      for (int unsigned i = 0; i < 6; i++) begin
         tick();
         check_eq("s1_valid", 32'(ir_valid), 1);
         check_eq("s1_ir_pc", 32'(ir_pc), i);
         check_eq("s1_pc", 32'(pc), i + 1);
      end
      check_eq("s1_halted", 32'(halted), 1);
      tick();
      check_eq("s1_drained", 32'(ir_valid), 0);
      check_eq("s1_pc_hold", 32'(pc), 6);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check_eq("s1_start_in_halt", 32'(halted), 1);
      check_eq("s1_no_more", 32'(ir_valid), 0);
      check_eq("s1_pc_final", 32'(pc), 6);

      // ---- 4 + 2: redirect out of HALT, then backpressure on addr2
      push_range(0, 5);
      redirect_valid = 1'b1; redirect_addr = 6'd0;
      tick();
      redirect_valid = 1'b0;
      check_eq("s4_halted", 32'(halted), 0);
      check_eq("s4_pc", 32'(pc), 0);
      check_eq("s4_valid", 32'(ir_valid), 0);
      tick();
      check_eq("s4_resume_pc0", 32'(ir_pc), 0);
      tick();
      tick();
      check_eq("s2_ir_pc2", 32'(ir_pc), 2);
      ir_ready = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         check_eq("s2_hold_valid", 32'(ir_valid), 1);
         check_eq("s2_hold_code", 32'(ir_code), 32'h020002);
         check_eq("s2_hold_pc", 32'(pc), 3);
      end
      ir_ready = 1'b1;
      tick();
      check_eq("s2_release_pc3", 32'(ir_pc), 3);
      tick(); tick();
      check_eq("s2_halted", 32'(halted), 1);
      tick();
      check_eq("s2_drained", 32'(ir_valid), 0);

      // ---- 3: redirect to 4 while addr1 held with ir_ready=1
      push_range(0, 0);
      push_range(4, 5);
      redirect_valid = 1'b1; redirect_addr = 6'd0;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      check_eq("s3_ir_pc1", 32'(ir_pc), 1);
      redirect_valid = 1'b1; redirect_addr = 6'd4;
      tick();
      redirect_valid = 1'b0;
      check_eq("s3_flush_valid", 32'(ir_valid), 0);
      check_eq("s3_flush_pc", 32'(pc), 4);
      tick();
      check_eq("s3_next_valid", 32'(ir_valid), 1);
      check_eq("s3_next_ir_pc", 32'(ir_pc), 4);
      tick();
      check_eq("s3_halted", 32'(halted), 1);
      tick();

      // ---- 6: reset mid-stream, IDLE redirect, start+redirect, start in FETCH
      redirect_valid = 1'b1; redirect_addr = 6'd0;
      tick();
      redirect_valid = 1'b0;
      ir_ready = 1'b0;
      tick(); tick();
      check_eq("s6_held", 32'(ir_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("s6_rst_valid", 32'(ir_valid), 0);
      check_eq("s6_rst_pc", 32'(pc), 0);
      check_eq("s6_rst_halted", 32'(halted), 0);
      ir_ready = 1'b1;
      redirect_valid = 1'b1; redirect_addr = 6'd3;
      tick();
      redirect_valid = 1'b0;
      check_eq("s6_idle_redirect_pc", 32'(pc), 3);
      tick();
      check_eq("s6_idle_stays", 32'(ir_valid), 0);
      check_eq("s6_idle_pc_hold", 32'(pc), 3);
      push_range(1, 5);
      start = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd1;
      tick();
      start = 1'b0; redirect_valid = 1'b0;
      check_eq("s6_start_redir_pc", 32'(pc), 1);
      tick();
      check_eq("s6_first_ir_pc", 32'(ir_pc), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("s6_start_ignored_ir_pc", 32'(ir_pc), 2);
      check_eq("s6_start_ignored_pc", 32'(pc), 3);
      tick(); tick(); tick();
      check_eq("s6_halted", 32'(halted), 1);
      tick();
      check_eq("s6_drained", 32'(ir_valid), 0);

      // ---- 5: RESET_PC=62 wraps
      tick();
      rst1 = 1'b0;
      check_eq("s5_rst_pc", 32'(pc1), 62);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         tick();
         check_eq("s5_valid", 32'(ir_valid1), 1);
         check_eq("s5_ir_pc", 32'(ir_pc1), (62 + i) % 64);
      end
      check_eq("s5_pc_wrapped", 32'(pc1), 2);
      check_eq("s5_not_halted", 32'(halted1), 0);

      check_eq("sb_leftover", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
